// File: rtl/cf_math_pkg.sv
// Shared math helpers: index width for an N-entry structure (at least 1 bit).
package cf_math_pkg;
  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
  endfunction
endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter. MODE=0 counts trailing zeros (lowest set bit index),
// MODE=1 counts leading zeros. empty_o flags an all-zero input (cnt_o is then 0).
module lzc #(
  parameter int unsigned WIDTH     = 2,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = cf_math_pkg::idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);
  // Scan toward the winning end so the last hit overrides earlier ones.
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      int j;
      j = MODE ? i : int'(WIDTH) - 1 - i;
      if (in_i[j]) cnt_o = MODE ? CNT_WIDTH'(int'(WIDTH) - 1 - j) : CNT_WIDTH'(j);
    end
  end

  assign empty_o = ~|in_i;
endmodule

// File: rtl/id_bitmap_alloc.sv
// Outstanding-ID bitmap allocator: lowest-free grant, one-hot release, occupancy count.
// Define ID_ALLOC_ERR_CHECK_EN to enable err_o pulses on illegal frees.
module id_bitmap_alloc #(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned IDX_WIDTH = cf_math_pkg::idx_width(NUM_SLOTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 alloc_req_i,
  output logic                 alloc_gnt_o,
  output logic [IDX_WIDTH-1:0] alloc_idx_o,
  input  logic                 free_valid_i,
  input  logic [IDX_WIDTH-1:0] free_idx_i,
  output logic [NUM_SLOTS-1:0] busy_o,
  output logic [IDX_WIDTH:0]   count_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 err_o
);
  logic [NUM_SLOTS-1:0] r_busy;
  logic [IDX_WIDTH:0]   r_count;
  logic [IDX_WIDTH-1:0] w_lzc_cnt;
  logic                 w_full;
  logic                 w_in_range, w_hit, w_legal_free;
  logic [NUM_SLOTS-1:0] w_clr, w_set;

  lzc #(.WIDTH(NUM_SLOTS), .MODE(1'b0), .CNT_WIDTH(IDX_WIDTH)) i_lzc (
    .in_i    (~r_busy),
    .cnt_o   (w_lzc_cnt),
    .empty_o (w_full)
  );

  assign full_o      = w_full;
  assign empty_o     = ~|r_busy;
  assign busy_o      = r_busy;
  assign count_o     = r_count;
  assign alloc_gnt_o = alloc_req_i & ~w_full & ~flush_i;
  assign alloc_idx_o = w_full ? '0 : w_lzc_cnt;

  assign w_in_range   = 32'(free_idx_i) < NUM_SLOTS;
  assign w_clr        = (free_valid_i && w_in_range) ? (NUM_SLOTS'(1) << free_idx_i) : '0;
  assign w_hit        = |(w_clr & r_busy);
  assign w_legal_free = w_hit & ~flush_i;
  assign w_set        = alloc_gnt_o ? (NUM_SLOTS'(1) << alloc_idx_o) : '0;

  // Granted slot is free in r_busy and a legal clear hits a busy slot, so they never collide.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      r_busy  <= (r_busy & ~w_clr) | w_set;
      r_count <= r_count + (IDX_WIDTH+1)'(alloc_gnt_o) - (IDX_WIDTH+1)'(w_legal_free);
    end
  end

`ifdef ID_ALLOC_ERR_CHECK_EN
  logic r_err;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_err <= 1'b0;
    else         r_err <= free_valid_i & ~flush_i & ~w_hit;
  end
  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif
endmodule
